bcd_countdown_monitor: RTL and testbench



---
 rtl/bcd_countdown_monitor_if.sv | 35 +++
 rtl/bcd_countdown_monitor.sv | 168 ++++++++++++++++
 tb/tb_bcd_countdown_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_countdown_monitor_if.sv
// Bundle between the BCD down-counter, the monitor and the display/status logic.
// The seg signal exists only when SEG_OUT_EN is defined.
interface bcd_countdown_monitor_if #(
    parameter int RUN_W = 8
);
    logic [3:0]       count_in;
    logic             count_vld;
    logic             clr_err;
    logic             run_done;
    logic             zero_flag;
    logic             err;
    logic [1:0]       err_code;
    logic [RUN_W-1:0] run_cnt;
    logic [1:0]       state;
`ifdef SEG_OUT_EN
    logic [6:0]       seg;
`endif

    // count_vld is a strobe with no ready: every cycle it is high, count_in is consumed.
    modport master (
        output count_in, count_vld, clr_err,
        input  run_done, zero_flag, err, err_code, run_cnt, state
`ifdef SEG_OUT_EN
        , seg
`endif
    );

    modport slave (
        input  count_in, count_vld, clr_err,
        output run_done, zero_flag, err, err_code, run_cnt, state
`ifdef SEG_OUT_EN
        , seg
`endif
    );
endinterface

// File: rtl/bcd_countdown_monitor.sv
// Checks that a 9..0 BCD down-counter steps by one per valid sample, counts runs, flags errors.
// Optional seven-segment output is built only when SEG_OUT_EN is defined.
module bcd_countdown_monitor #(
    parameter int START_VAL = 9,
    parameter int RUN_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_countdown_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    localparam logic [3:0] START_CODE = 4'(START_VAL);
    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_ILL   = 2'b01;
    localparam logic [1:0] CODE_SKIP  = 2'b10;
    localparam logic [1:0] CODE_UNDER = 2'b11;

    state_t           state_q;
    logic [3:0]       prev_q;
    logic             run_done_q;
    logic             zero_flag_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [RUN_W-1:0] run_cnt_q;

    logic             illegal;
    logic             enter_err_d;
    logic [1:0]       err_code_d;
    logic [RUN_W-1:0] run_cnt_d;

    assign illegal   = (mon.count_in >= 4'd10) && (mon.count_in <= 4'd14);
    assign run_cnt_d = (&run_cnt_q) ? run_cnt_q : run_cnt_q + RUN_W'(1);

    // Classify the current sample against the tracked value.
    always_comb begin
        enter_err_d = 1'b0;
        err_code_d  = CODE_NONE;
        if (mon.count_vld) begin
            case (state_q)
                IDLE: begin
                    if (illegal) begin
                        enter_err_d = 1'b1;
                        err_code_d  = CODE_ILL;
                    end
                end
                TRACK: begin
                    if (mon.count_in == prev_q || mon.count_in == prev_q - 4'd1 ||
                        mon.count_in == START_CODE) begin
                        enter_err_d = 1'b0;
                    end else if (mon.count_in == 4'hF) begin
                        enter_err_d = 1'b1;
                        err_code_d  = CODE_UNDER;
                    end else if (illegal) begin
                        enter_err_d = 1'b1;
                        err_code_d  = CODE_ILL;
                    end else begin
                        enter_err_d = 1'b1;
                        err_code_d  = CODE_SKIP;
                    end
                end
                default: enter_err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            prev_q      <= 4'd0;
            run_done_q  <= 1'b0;
            zero_flag_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= CODE_NONE;
            run_cnt_q   <= '0;
        end else begin
            run_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enter_err_d) begin
                        state_q    <= ERROR;
                        err_q      <= 1'b1;
                        err_code_q <= err_code_d;
                    end else if (mon.count_vld && mon.count_in == START_CODE) begin
                        prev_q      <= START_CODE;
                        zero_flag_q <= 1'b0;
                        state_q     <= TRACK;
                    end
                end
                TRACK: begin
                    if (enter_err_d) begin
                        state_q    <= ERROR;
                        err_q      <= 1'b1;
                        err_code_q <= err_code_d;
                    end else if (mon.count_vld && mon.count_in != prev_q) begin
                        // Either a one-step decrement or a resync to the start value.
                        prev_q      <= mon.count_in;
                        zero_flag_q <= (mon.count_in == 4'd0);
                        if (mon.count_in == 4'd0) begin
                            run_done_q <= 1'b1;
                            run_cnt_q  <= run_cnt_d;
                            state_q    <= IDLE;
                        end
                    end
                end
                ERROR: begin
                    if (mon.clr_err) begin
                        state_q    <= IDLE;
                        err_q      <= 1'b0;
                        err_code_q <= CODE_NONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mon.run_done  = run_done_q;
    assign mon.zero_flag = zero_flag_q;
    assign mon.err       = err_q;
    assign mon.err_code  = err_code_q;
    assign mon.run_cnt   = run_cnt_q;
    assign mon.state     = state_q;

`ifdef SEG_OUT_EN
    localparam logic [6:0] SEG_DASH = 7'h40;

    logic [6:0] seg_q;
    logic [6:0] seg_d;

    always_comb begin
        case (mon.count_in)
            4'd0:    seg_d = 7'h3F;
            4'd1:    seg_d = 7'h06;
            4'd2:    seg_d = 7'h5B;
            4'd3:    seg_d = 7'h4F;
            4'd4:    seg_d = 7'h66;
            4'd5:    seg_d = 7'h6D;
            4'd6:    seg_d = 7'h7D;
            4'd7:    seg_d = 7'h07;
            4'd8:    seg_d = 7'h7F;
            4'd9:    seg_d = 7'h6F;
            default: seg_d = SEG_DASH;
        endcase
    end

    // The dash holds for the whole error episode; clearing blanks the digit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_q <= 7'h00;
        end else if (state_q == ERROR) begin
            if (mon.clr_err) begin
                seg_q <= 7'h00;
            end
        end else if (mon.count_vld) begin
            seg_q <= enter_err_d ? SEG_DASH : seg_d;
        end
    end

    assign mon.seg = seg_q;
`endif

endmodule

// File: tb/tb_bcd_countdown_monitor.sv
// Directed bench for bcd_countdown_monitor; seg checks are added when SEG_OUT_EN is defined.
module tb_bcd_countdown_monitor;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bcd_countdown_monitor_if #(.RUN_W(8)) mon_if ();

    bcd_countdown_monitor #(
        .START_VAL(9),
        .RUN_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at negedge; outputs are sampled 1 time unit after the posedge.
    task automatic drive(input logic vld, input logic [3:0] val, input logic clr, input logic rst_v);
        @(negedge clk);
        rst              = rst_v;
        mon_if.count_vld = vld;
        mon_if.count_in  = val;
        mon_if.clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] val);
        drive(1'b1, val, 1'b0, 1'b1);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic full_run();
        for (int v = 9; v >= 0; v--) sample(4'(v));
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input logic e,
                                input logic [1:0] code, input logic [7:0] rc);
        check({tag, "_state"},    32'(mon_if.state),    32'(st));
        check({tag, "_err"},      32'(mon_if.err),      32'(e));
        check({tag, "_err_code"}, 32'(mon_if.err_code), 32'(code));
        check({tag, "_run_cnt"},  32'(mon_if.run_cnt),  32'(rc));
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b0;
        mon_if.count_vld = 1'b0;
        mon_if.count_in  = 4'd0;
        mon_if.clr_err   = 1'b0;

        // Reset values
        do_reset();
        check_status("reset", 2'b00, 1'b0, 2'b00, 8'd0);
        check("reset_run_done",  32'(mon_if.run_done),  32'd0);
        check("reset_zero_flag", 32'(mon_if.zero_flag), 32'd0);
`ifdef SEG_OUT_EN
        check("reset_seg", 32'(mon_if.seg), 32'h00);
`endif

        // One clean 9..0 run
        for (int v = 9; v >= 1; v--) begin
            sample(4'(v));
            check("run1_state", 32'(mon_if.state), 32'd1);
            check("run1_no_done", 32'(mon_if.run_done), 32'd0);
`ifdef SEG_OUT_EN
            if (v == 9) check("seg_nine", 32'(mon_if.seg), 32'h6F);
`endif
        end
        sample(4'd0);
        check_status("run1_end", 2'b00, 1'b0, 2'b00, 8'd1);
        check("run1_done", 32'(mon_if.run_done), 32'd1);
        check("run1_zero", 32'(mon_if.zero_flag), 32'd1);
`ifdef SEG_OUT_EN
        check("seg_zero", 32'(mon_if.seg), 32'h3F);
`endif
        idle();
        check("run1_done_pulse", 32'(mon_if.run_done), 32'd0);
        check("run1_zero_hold", 32'(mon_if.zero_flag), 32'd1);

        // Two runs each followed by the wrap code F
        do_reset();
        full_run();
        check("wrap_a_state", 32'(mon_if.state), 32'd0);
        sample(4'hF);
        check_status("wrap_a", 2'b00, 1'b0, 2'b00, 8'd1);
        full_run();
        check("wrap_b_state", 32'(mon_if.state), 32'd0);
        sample(4'hF);
        check_status("wrap_b", 2'b00, 1'b0, 2'b00, 8'd2);

        // Hold on repeated value and resync to the start value
        sample(4'd9);
        sample(4'd9);
        check_status("hold", 2'b01, 1'b0, 2'b00, 8'd2);
        sample(4'd8);
        sample(4'd9);
        check_status("resync", 2'b01, 1'b0, 2'b00, 8'd2);
        check("resync_zero", 32'(mon_if.zero_flag), 32'd0);

        // Skip 8 -> 6, samples dropped in ERROR, clear wins over a valid sample
        sample(4'd8);
        sample(4'd6);
        check_status("skip", 2'b10, 1'b1, 2'b10, 8'd2);
`ifdef SEG_OUT_EN
        check("seg_err", 32'(mon_if.seg), 32'h40);
`endif
        sample(4'd9);
        sample(4'd0);
        check_status("err_drop", 2'b10, 1'b1, 2'b10, 8'd2);
        check("err_no_done", 32'(mon_if.run_done), 32'd0);
        drive(1'b1, 4'd9, 1'b1, 1'b1);
        check_status("clr", 2'b00, 1'b0, 2'b00, 8'd2);

        // clr_err outside ERROR is ignored
        drive(1'b1, 4'd9, 1'b1, 1'b1);
        check_status("clr_noerr", 2'b01, 1'b0, 2'b00, 8'd2);
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        check_status("clr_noerr2", 2'b01, 1'b0, 2'b00, 8'd2);

        // Illegal code while tracking
        sample(4'hC);
        check_status("ill_track", 2'b10, 1'b1, 2'b01, 8'd2);
        drive(1'b0, 4'd0, 1'b1, 1'b1);

        // Illegal code in IDLE
        sample(4'hB);
        check_status("ill_idle", 2'b10, 1'b1, 2'b01, 8'd2);
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        check_status("ill_clr", 2'b00, 1'b0, 2'b00, 8'd2);

        // Underflow: 9..5 then F
        for (int v = 9; v >= 5; v--) sample(4'(v));
        sample(4'hF);
        check_status("under", 2'b10, 1'b1, 2'b11, 8'd2);
        drive(1'b0, 4'd0, 1'b1, 1'b1);

        // Saturation of run_cnt at 255, run_done still pulses
        do_reset();
        for (int r = 0; r < 255; r++) full_run();
        check("sat_255", 32'(mon_if.run_cnt), 32'd255);
        full_run();
        check("sat_hold", 32'(mon_if.run_cnt), 32'd255);
        check("sat_done", 32'(mon_if.run_done), 32'd1);

        // Reset asserted on the cycle the final 0 arrives
        for (int v = 9; v >= 1; v--) sample(4'(v));
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        check_status("rst_mid", 2'b00, 1'b0, 2'b00, 8'd0);
        check("rst_mid_done", 32'(mon_if.run_done), 32'd0);
        check("rst_mid_zero", 32'(mon_if.zero_flag), 32'd0);
        idle();
        check("rst_mid_done2", 32'(mon_if.run_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
